// File: rtl/icache_dm_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_types;

  localparam int OFFSET_W = 5;                   // byte-offset bits of a line
  localparam int LINE_W   = 8 * (1 << OFFSET_W); // line width in bits
  localparam int WSEL_W   = OFFSET_W - 2;        // 32-bit word select within a line

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } icache_state_t;

  // Pick one 32-bit word out of a cache line; word 0 is bits [31:0].
  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] word_idx);
    return line[{word_idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Flop array with one write port and one combinational read port.
// HAS_RST selects the variant whose entries clear on async reset (valid bits).
module icache_array #(
  parameter int WIDTH   = 1,
  parameter int IDX_W   = 3,
  parameter bit HAS_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_windex,
  input  logic [IDX_W-1:0] i_rindex,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  generate
    if (HAS_RST) begin : g_rst
      // Resettable storage: every entry cleared while rst is low.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
          end
        end else if (i_load) begin
          r_mem[i_windex] <= i_wdata;
        end
      end
    end else begin : g_norst
      logic w_unused_rst;
      assign w_unused_rst = rst;
      // Plain storage: contents are only meaningful once the valid bit is set.
      always_ff @(posedge clk) begin
        if (i_load) begin
          r_mem[i_windex] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_rdata = r_mem[i_rindex];

endmodule

// File: rtl/icache_dm_chk.sv
// Protocol checker: the fetch port must never request a write.
module icache_dm_chk (
  input logic clk,
  input logic rst,
  input logic i_write
);

  a_no_write: assert property (@(posedge clk) disable iff (!rst) i_write == 1'b0);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-line
// fill from pmem on a miss through IDLE -> FETCH -> FILL -> IDLE.
module icache_dm
  import icache_types::*;
#(
  parameter int S_OFFSET = OFFSET_W,
  parameter int S_INDEX  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            icache_read,
  input  logic                            icache_write,
  input  logic [31:0]                     icache_addr,
  output logic [31:0]                     icache_rdata,
  output logic                            icache_resp,
  output logic                            pmem_read,
  output logic [31:0]                     pmem_address,
  input  logic [8*(1<<S_OFFSET)-1:0]      pmem_rdata,
  input  logic                            pmem_resp
);

  localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
  localparam int S_LINE = 8 * (1 << S_OFFSET);

  icache_state_t r_state;
  icache_state_t w_state_next;

  logic [31-S_OFFSET:0] r_miss_line;   // {tag, index} of the line being fetched
  logic [S_LINE-1:0]    r_fill_buf;

  logic [S_INDEX-1:0]   w_index;
  logic [S_TAG-1:0]     w_tag;
  logic [S_INDEX-1:0]   w_miss_index;
  logic [S_TAG-1:0]     w_miss_tag;
  logic [S_LINE-1:0]    w_data_rd;
  logic [S_TAG-1:0]     w_tag_rd;
  logic                 w_valid_rd;
  logic                 w_hit;
  logic                 w_fill;
  logic                 w_miss_latch;
  logic                 w_buf_load;
  logic [1:0]           w_unused_byte;

  assign w_index       = icache_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_tag         = icache_addr[31:S_OFFSET+S_INDEX];
  assign w_miss_index  = r_miss_line[S_INDEX-1:0];
  assign w_miss_tag    = r_miss_line[31-S_OFFSET:S_INDEX];
  assign w_fill        = (r_state == FILL);
  assign w_hit         = w_valid_rd && (w_tag_rd == w_tag);
  assign w_unused_byte = icache_addr[1:0];

  icache_array #(.WIDTH(S_LINE), .IDX_W(S_INDEX), .HAS_RST(1'b0)) u_data (
    .clk(clk), .rst(rst), .i_load(w_fill), .i_windex(w_miss_index),
    .i_rindex(w_index), .i_wdata(r_fill_buf), .o_rdata(w_data_rd)
  );

  icache_array #(.WIDTH(S_TAG), .IDX_W(S_INDEX), .HAS_RST(1'b0)) u_tag (
    .clk(clk), .rst(rst), .i_load(w_fill), .i_windex(w_miss_index),
    .i_rindex(w_index), .i_wdata(w_miss_tag), .o_rdata(w_tag_rd)
  );

  icache_array #(.WIDTH(1), .IDX_W(S_INDEX), .HAS_RST(1'b1)) u_valid (
    .clk(clk), .rst(rst), .i_load(w_fill), .i_windex(w_miss_index),
    .i_rindex(w_index), .i_wdata(1'b1), .o_rdata(w_valid_rd)
  );

  icache_dm_chk u_chk (.clk(clk), .rst(rst), .i_write(icache_write));

  // FSM state register; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the line address of a missing request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_line <= {(32-S_OFFSET){1'b0}};
    end else if (w_miss_latch) begin
      r_miss_line <= icache_addr[31:S_OFFSET];
    end
  end

  // Hold the returned pmem line until it is written in FILL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_buf <= {S_LINE{1'b0}};
    end else if (w_buf_load) begin
      r_fill_buf <= pmem_rdata;
    end
  end

  // Next-state logic and fetch/pmem port outputs.
  always_comb begin
    w_state_next = r_state;
    icache_resp  = 1'b0;
    icache_rdata = 32'h0000_0000;
    pmem_read    = 1'b0;
    pmem_address = 32'h0000_0000;
    w_miss_latch = 1'b0;
    w_buf_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (icache_read) begin
          if (w_hit) begin
            icache_resp  = 1'b1;
            icache_rdata = word_sel(w_data_rd, icache_addr[S_OFFSET-1:2]);
          end else begin
            w_miss_latch = 1'b1;
            w_state_next = FETCH;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {r_miss_line, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          w_buf_load   = 1'b1;
          w_state_next = FILL;
        end else begin
          w_state_next = FETCH;
        end
      end
      FILL: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: scoreboard of expected instruction words,
// automatic pmem responder with programmable latency, scenario tasks.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read;
  logic         icache_write;
  logic [31:0]  icache_addr;
  logic [31:0]  icache_rdata;
  logic         icache_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];      // expected instruction words
  logic [31:0] pmem_log[$];  // addresses served by the pmem model
  bit          pmem_auto = 1'b1;
  int          pmem_lat  = 5;
  int          pm_cnt    = 0;

  icache_dm dut (
    .clk(clk), .rst(rst), .icache_read(icache_read), .icache_write(icache_write),
    .icache_addr(icache_addr), .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .pmem_read(pmem_read), .pmem_address(pmem_address), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory contents: every word depends on its line address and position;
  // the line at 0x60 starts with the instruction 0x00A00093.
  function automatic logic [255:0] line_for(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      l[w*32 +: 32] = (la + 32'(w)) ^ 32'h1357_0000;
    end
    if (la == 32'h0000_0060) l[31:0] = 32'h00A0_0093;
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [255:0] l;
    logic [2:0]   s;
    l = line_for({a[31:5], 5'b00000});
    s = a[4:2];
    return l[int'(s)*32 +: 32];
  endfunction

  // pmem model: answers on the pmem_lat-th consecutive cycle of pmem_read.
  initial begin
    forever begin
      @(negedge clk);
      if (pmem_auto) begin
        if (pmem_read) begin
          pm_cnt++;
          if (pm_cnt >= pmem_lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = line_for(pmem_address);
            pmem_log.push_back(pmem_address);
            pm_cnt = 0;
          end else begin
            pmem_resp = 1'b0;
          end
        end else begin
          pm_cnt    = 0;
          pmem_resp = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Issue one request, optionally moving the address at cycle sw_cyc, and
  // compare the response with the scoreboard and the expected latency.
  task automatic read_req(input logic [31:0] addr, input int exp_lat,
                          input int sw_cyc, input logic [31:0] sw_addr, input string name);
    int lat;
    bit got;
    logic [31:0] exp_w;
    sb_q.push_back(word_of((sw_cyc > 0) ? sw_addr : addr));
    @(negedge clk);
    icache_read = 1'b1;
    icache_addr = addr;
    #1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 80) begin
      if (icache_resp) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
        if (sw_cyc > 0 && lat == sw_cyc) icache_addr = sw_addr;
        #1;
      end
    end
    exp_w = sb_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_resp: no icache_resp after %0d cycles, required one", name, lat);
    end else begin
      if (icache_rdata !== exp_w) begin
        errors++;
        $display("FAIL %s_rdata: got %h required %h", name, icache_rdata, exp_w);
      end
      if (exp_lat >= 0) begin
        checks++;
        if (lat != exp_lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
      end
    end
    icache_read = 1'b0;
  endtask

  task automatic check_last_pmem(input logic [31:0] exp_a, input string name);
    checks++;
    if (pmem_log.size() == 0) begin
      errors++;
      $display("FAIL %s_pmem_addr: no fill seen, required %h", name, exp_a);
    end else if (pmem_log[$] !== exp_a) begin
      errors++;
      $display("FAIL %s_pmem_addr: got %h required %h", name, pmem_log[$], exp_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    icache_read = 1'b0;
    icache_write = 1'b0;
    icache_addr = 32'h0;
    pmem_resp = 1'b0;
    pmem_rdata = 256'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (icache_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: resp=%b pmem_read=%b required 0/0", icache_resp, pmem_read);
    end
    checks++;
    if (pmem_address !== 32'h0 || icache_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: pmem_address=%h rdata=%h required 0/0", pmem_address, icache_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int n;
    pmem_lat = 5;
    n = pmem_log.size();
    read_req(32'h0000_0060, 7, 0, 32'h0, "cold_miss");
    checks++;
    if (pmem_log.size() != n + 1) begin
      errors++;
      $display("FAIL cold_miss_fills: got %0d required 1", pmem_log.size() - n);
    end
    check_last_pmem(32'h0000_0060, "cold_miss");
  endtask

  task automatic test_hit();
    int n;
    n = pmem_log.size();
    read_req(32'h0000_0064, 0, 0, 32'h0, "hit");
    checks++;
    if (pmem_read !== 1'b0 || pmem_log.size() != n) begin
      errors++;
      $display("FAIL hit_no_fetch: pmem_read=%b fills=%0d required 0/0", pmem_read, pmem_log.size() - n);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      read_req(32'h0000_0060 + 32'(i*4), 0, 0, 32'h0, "b2b");
    end
  endtask

  task automatic test_conflict();
    read_req(32'h0000_0160, 7, 0, 32'h0, "conflict_new");
    check_last_pmem(32'h0000_0160, "conflict_new");
    read_req(32'h0000_0060, 7, 0, 32'h0, "conflict_old");
    check_last_pmem(32'h0000_0060, "conflict_old");
  endtask

  task automatic test_reset_mid_fetch();
    pmem_auto = 1'b0;
    pmem_resp = 1'b0;
    @(negedge clk);
    icache_read = 1'b1;
    icache_addr = 32'h0000_0080;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0080) begin
      errors++;
      $display("FAIL rmf_fetch: pmem_read=%b addr=%h required 1/00000080", pmem_read, pmem_address);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      errors++;
      $display("FAIL rmf_async: pmem_read=%b addr=%h required 0/0", pmem_read, pmem_address);
    end
    icache_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = {8{$urandom()}};
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || icache_resp !== 1'b0) begin
      errors++;
      $display("FAIL rmf_stale: pmem_read=%b resp=%b required 0/0", pmem_read, icache_resp);
    end
    pmem_auto = 1'b1;
    read_req(32'h0000_0060, 7, 0, 32'h0, "rmf_refill");
    check_last_pmem(32'h0000_0060, "rmf_refill");
  endtask

  task automatic test_addr_change();
    int n;
    pmem_lat = 3;
    n = pmem_log.size();
    read_req(32'h0000_0020, 10, 2, 32'h0000_0040, "addr_chg");
    checks++;
    if (pmem_log.size() != n + 2) begin
      errors++;
      $display("FAIL addr_chg_fills: got %0d required 2", pmem_log.size() - n);
    end else begin
      checks++;
      if (pmem_log[n] !== 32'h0000_0020 || pmem_log[n+1] !== 32'h0000_0040) begin
        errors++;
        $display("FAIL addr_chg_order: got %h,%h required 00000020,00000040", pmem_log[n], pmem_log[n+1]);
      end
    end
    read_req(32'h0000_0024, 0, 0, 32'h0, "addr_chg_kept");
  endtask

  task automatic test_idle();
    icache_read = 1'b0;
    icache_addr = 32'h0000_0060;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (icache_resp !== 1'b0 || pmem_read !== 1'b0 || icache_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_outputs: resp=%b pmem_read=%b rdata=%h required 0/0/0",
                 icache_resp, pmem_read, icache_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_reset_mid_fetch();
    test_addr_change();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
